// File: rtl/riscv_cpu_pkg.sv
// Shared CPU definitions: load/store size codes, data width, and the
// data-memory slave state and request types.
package riscv_cpu_pkg;

  localparam int DATA_WIDTH = 32;

  // funct3 size/sign codes for loads
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  // funct3 size codes for stores
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

  typedef struct packed {
    logic                  we;
    logic [31:0]           addr;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] wdata;
  } dmem_req_t;

  // True when funct3 names a real access of the given direction.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == SB) || (f3 == SH) || (f3 == SW);
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

endpackage

// File: rtl/riscv_dmem_slave_if.sv
// Bundle of the data-memory request/response signals.
// master: drives req/we/addr/funct3/wdata, sees gnt/rvalid/rdata/err.
// slave : the opposite direction.
interface riscv_dmem_slave_if;
  import riscv_cpu_pkg::*;

  logic                  req;
  logic                  we;
  logic [31:0]           addr;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (output req, we, addr, funct3, wdata,
                  input  gnt, rvalid, rdata, err);
  modport slave  (input  req, we, addr, funct3, wdata,
                  output gnt, rvalid, rdata, err);
endinterface

// File: rtl/riscv_dmem_lane.sv
// Byte-lane steering for stores and lane select + extension for loads.
// Inputs : funct3_i (size/sign), addr_i (byte offset), wdata_i (LSB-aligned
//          store data), rword_i (stored word).
// Outputs: be_o (byte enables), wword_o (store data replicated onto lanes),
//          rdata_o (extended load result).
// Halfword/word offsets are always aligned down; misalignment is judged by
// the caller.
module riscv_dmem_lane
  import riscv_cpu_pkg::*;
(
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rword_i,
  output logic [3:0]            be_o,
  output logic [DATA_WIDTH-1:0] wword_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [1:0]            off;
  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    off     = 2'b00;
    be_o    = 4'b0000;
    wword_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin off = addr_i;              be_o = 4'b0001 << off; wword_o = {4{wdata_i[7:0]}};  end
      2'b01: begin off = {addr_i[1], 1'b0};   be_o = 4'b0011 << off; wword_o = {2{wdata_i[15:0]}}; end
      2'b10: begin off = 2'b00;               be_o = 4'b1111;        wword_o = wdata_i;            end
      default: ;
    endcase

    shifted = rword_i >> {off, 3'b000};
    case (funct3_i)
      LB:      rdata_o = {{24{shifted[7]}},  shifted[7:0]};
      LH:      rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      LW:      rdata_o = rword_i;
      LBU:     rdata_o = {24'h0, shifted[7:0]};
      LHU:     rdata_o = {16'h0, shifted[15:0]};
      default: rdata_o = '0;
    endcase
  end
endmodule

// File: rtl/riscv_dmem.sv
// riscv_dmem_slave: single-outstanding data-memory slave for the core MEM
// stage. Grants in IDLE, waits WAIT_CYCLES, then returns a one-cycle
// response. Stores commit on the edge that enters RESP.
// Ports: clk_i, rst_ni (async active-low), req_i/we_i/addr_i/funct3_i/wdata_i
//        request; gnt_o grant; rvalid_o/rdata_o/err_o response.
// Config: define RISCV_DMEM_MISALIGN_CHECK_EN to flag misaligned halfword/word
//         accesses as errors; otherwise such addresses are aligned down.
module riscv_dmem_slave
  import riscv_cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  dmem_state_e           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  dmem_req_t             req_q, req_d;
  logic                  rvalid_q, rvalid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  dmem_req_t             cur;
  logic                  enter_resp, oob, bad_f3, misalign, acc_err, commit;
  logic [29:0]           idx;
  logic [AW-1:0]         widx;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wword, lane_rdata;

  // With WAIT_CYCLES=0 the access completes on the granting edge, so the
  // live inputs must be used before they are latched.
  always_comb cur = (state_q == IDLE) ? '{we: we_i, addr: addr_i, funct3: funct3_i, wdata: wdata_i}
                                      : req_q;

  assign gnt_o = req_i && (state_q == IDLE) && rst_ni;
  assign idx   = cur.addr[31:2];
  assign widx  = idx[AW-1:0];
  assign oob   = {2'b00, idx} >= 32'(DEPTH_WORDS);
  assign bad_f3 = !funct3_legal(cur.we, cur.funct3);
`ifdef RISCV_DMEM_MISALIGN_CHECK_EN
  assign misalign = ((cur.funct3[1:0] == 2'b01) && cur.addr[0]) ||
                    ((cur.funct3[1:0] == 2'b10) && (cur.addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign acc_err = oob || bad_f3 || misalign;

  riscv_dmem_lane u_lane (
    .funct3_i (cur.funct3),
    .addr_i   (cur.addr[1:0]),
    .wdata_i  (cur.wdata),
    .rword_i  (mem[widx]),
    .be_o     (be),
    .wword_o  (wword),
    .rdata_o  (lane_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: if (req_i) begin
        req_d = cur;
        if (WAIT_CYCLES == 0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d    = RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rvalid_d = enter_resp;
    err_d    = enter_resp && acc_err;
    rdata_d  = (enter_resp && !acc_err && !cur.we) ? lane_rdata : '0;
  end

  // Reset gating keeps a request held during reset from writing memory.
  assign commit = enter_resp && cur.we && !acc_err && rst_ni;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      req_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++)
      if (commit && be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
endmodule

// File: doc/riscv_dmem_slave.md
RISCV_DMEM_SLAVE -- requirements
Module: riscv_dmem_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra cycles between grant and response (0..15).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_i  input  1  access request from the core MEM stage.
REQ-006 SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port addr_i  input  32  byte address.
REQ-008 SHALL have port funct3_i  input  3  size/sign code, with LB/LH/LW/LBU/LHU for loads and SB/SH/SW for stores, as defined in riscv_cpu_pkg.
REQ-009 SHALL have port wdata_i  input  DATA_WIDTH  store data, LSB-aligned.
REQ-010 SHALL have port gnt_o  output  1  request accepted this cycle.
REQ-011 SHALL have port rvalid_o  output  1  response valid; one-cycle pulse.
REQ-012 SHALL have port rdata_o  output  DATA_WIDTH  load result, extended to 32 bits; 0 for stores and errors.
REQ-013 SHALL have port err_o  output  1  access error, qualified by rvalid_o.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-015 SHALL assert gnt_o = req_i combinationally, only in IDLE; gnt_o SHALL be 0 in WAIT and RESP.
REQ-016 SHALL latch we_i, addr_i, funct3_i and wdata_i on the granting edge.
REQ-017 On grant, SHALL go to WAIT if WAIT_CYCLES>0, otherwise to RESP.
REQ-018 In WAIT, SHALL count down from WAIT_CYCLES-1 and go to RESP when the count is 0.
REQ-019 In RESP, SHALL drive rvalid_o=1 for exactly one cycle, then return to IDLE; latency from grant to rvalid_o is WAIT_CYCLES+1 cycles.
REQ-020 SHALL allow at most one outstanding access; a new grant is possible no earlier than the cycle after RESP.
REQ-021 SHALL commit a store on the edge that enters RESP, using byte enables SB=1 lane, SH=2 lanes, SW=4 lanes, selected by addr[1:0]; unselected bytes SHALL be unchanged.
REQ-022 For loads, SHALL select the byte/halfword at addr[1:0]; LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL return the word.
REQ-023 SHALL use word index addr[31:2]; an index >= DEPTH_WORDS SHALL give err_o=1 with no write and rdata_o=0.
REQ-024 An illegal funct3 (load 3'b011/110/111, store >= 3'b011) SHALL give err_o=1 with no write.
REQ-025 A load SHALL return data that reflects a store completed in any earlier RESP cycle.
REQ-026 rdata_o and err_o SHALL be 0 whenever rvalid_o=0.

Reset
REQ-027 While rst_ni=0: state=IDLE, counter=0, gnt_o/rvalid_o/err_o=0, rdata_o=0.
REQ-028 Reset asserted during WAIT or RESP SHALL abort the access: no store is committed and no rvalid_o is produced.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-030 With macro RISCV_DMEM_MISALIGN_CHECK_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL give err_o=1, no write and rdata_o=0.
REQ-031 Without RISCV_DMEM_MISALIGN_CHECK_EN, the address SHALL be aligned down (clear addr[0] for halfword, addr[1:0] for word) and no misalignment error SHALL be raised.

Structure
REQ-032 SHALL add dmem_state_e (IDLE/WAIT/RESP) and the struct dmem_req_t (we, addr, funct3, wdata) to riscv_cpu_pkg, and SHALL reuse the existing LB..LHU and SB..SW constants.
REQ-033 SHALL place byte-lane steering and load extension in a combinational sub-module riscv_dmem_lane (inputs: funct3, addr[1:0], wdata, rword; outputs: be[3:0], wword, rdata).

Verification
REQ-034 WAIT_CYCLES=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> gnt_o in the request cycle, rvalid_o 2 cycles later, rdata_o=0xDEADBEEF, err_o=0.
REQ-035 SB 0x80 @0x13 over word 0x00000000, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80000000.
REQ-036 LH @0x12 with RISCV_DMEM_MISALIGN_CHECK_EN and word 0x1234ABCD -> 0x00001234; LH @0x11 -> err_o=1, rdata_o=0; without the macro, LH @0x11 -> 0xFFFFABCD.
REQ-037 DEPTH_WORDS=1024: SW @0x1000 -> err_o=1 and memory unchanged; load funct3=3'b111 -> err_o=1.
REQ-038 req_i held high continuously with WAIT_CYCLES=0 -> gnt_o pulses every 2nd cycle, one rvalid_o per grant.
REQ-039 rst_ni pulled low during WAIT of SW 0x55 @0x20 -> no rvalid_o, and a later LW @0x20 returns the prior value.
